mem_3_to_1_arbiter: RTL and testbench
=====================================

// Module: mem_3_to_1_arbiter
// PURPOSE
//  Round-robin arbiter that shares one single_port_mem (depth FULL_MEM_DEPTH) between three clients.
//  Each client owns a SINGLE_MEM_DEPTH window at its base address.
//  Handles simultaneous requests by valid/grant handshake (no silent priority drop).
//  Returns read data tagged with the client id after the fixed memory read latency.
//  Sits between the top controller's compute units and the shared operand memory.
// PARAMETERS
//  WIDTH               32  data word width
//  SINGLE_MEM_DEPTH    14  words per client window
//  FULL_MEM_DEPTH      42  physical memory depth (>= 3*SINGLE_MEM_DEPTH)
//  SINGLE_MEM_DEPTH_LOG  `CLOG2(SINGLE_MEM_DEPTH)  client address width
//  FULL_MEM_DEPTH_LOG    `CLOG2(FULL_MEM_DEPTH)    physical address width
//  MEM_0/1/2_START_ADDR  0/14/28  window base per client
//  RD_LATENCY           1  memory read latency in cycles (1..4)
// PORTS
//  clk            in   1      single clock
//  rst            in   1      synchronous, active-high reset
//  cN_req         in   1      client N (N=0,1,2) request; held until granted
//  cN_we          in   1      client N: 1=write, 0=read; stable while req
//  cN_addr        in   SINGLE_MEM_DEPTH_LOG  client-local word address
//  cN_din         in   WIDTH  client N write data
//  cN_gnt         out  1      transfer accepted this cycle (req & gnt)
//  rd_valid       out  1      read data valid on rd_data
//  rd_id          out  2      client id owning rd_data (0..2)
//  rd_data        out  WIDTH  read data (direct from memory q)
//  addr_err       out  1      sticky: a granted request had cN_addr >= SINGLE_MEM_DEPTH
//  mem_wr_en      out  1      to single_port_mem wr_en
//  mem_addr       out  FULL_MEM_DEPTH_LOG  to single_port_mem address
//  mem_din        out  WIDTH  to single_port_mem data
//  mem_q          in   WIDTH  from single_port_mem q
// BEHAVIOUR
//  - Reset values: all cN_gnt=0 during rst, rd_valid=0, rd_id=0, addr_err=0, mem_wr_en=0,
//    mem_addr=0, mem_din=0, rr pointer=0, read pipeline cleared.
//  - Arbitration: at most one grant per cycle; combinational from current reqs and rr pointer.
//    Search order starts at client ptr, then ptr+1, ptr+2 (mod 3).
//  - rr pointer update: on a grant to client k, ptr <= (k+1) mod 3 next cycle; no grant -> hold.
//  - Transfer: a transfer happens in a cycle where cN_req & cN_gnt.
//    In that same cycle mem_addr = cN_addr + MEM_N_START_ADDR (zero-extended, FULL_MEM_DEPTH_LOG bits),
//    mem_din=cN_din, mem_wr_en=cN_we.
//  - Idle cycles drive mem_wr_en=0, mem_addr=0, mem_din=0.
//  - Reads: a granted read pushes {valid=1,id=N} into an RD_LATENCY-deep shift pipeline.
//    The pipeline output drives rd_valid/rd_id, aligned with mem_q; rd_data=mem_q.
//  - Back-to-back reads from any clients are accepted every cycle; pipeline never stalls.
//  - Out-of-range local address: the request is granted, but memory is not touched.
//    mem_wr_en is forced 0 for a write; a read returns rd_data=0 with rd_valid=1.
//    addr_err is set and stays set until rst.
//  - Client dropping req without a grant: legal; no side effect.
//  - A client that keeps req high is granted at most once every 3 cycles when all three are requesting.
//  - Reset mid-operation: reads in flight are discarded (no rd_valid after rst), and ptr returns to 0.
//  - Write followed by read of the same address in the next cycle returns the new data.
// CONFIGURATION
//  - MEM_ARB_WR_FIRST_EN defined: pending writes beat pending reads.
//    Round-robin applies within the write class first, then within the read class.
//    The ptr update rule is unchanged.
//  - MEM_ARB_WR_FIRST_EN undefined: pure round-robin ignoring cN_we.
// TESTING
//  1. Reset release, no reqs for 5 cycles -> all gnt=0, mem_wr_en=0, rd_valid=0, addr_err=0.
//  2. c1 write addr 3 data 0xA5A5A5A5, then c1 read addr 3 ->
//     mem_addr=17 both cycles; rd_valid, rd_id=1, rd_data=0xA5A5A5A5 RD_LATENCY cycles after the read grant.
//  3. c0,c1,c2 all read held 6 cycles from ptr=0 -> grant order 0,1,2,0,1,2.
//     rd_id sequence is identical, delayed by RD_LATENCY.
//  4. c2 write addr 14 -> c2_gnt=1, mem_wr_en=0, addr_err=1 and stays 1 until rst.
//  5. c0 read granted, rst asserted the next cycle -> no rd_valid observed; after rst, ptr=0 (c0 wins a 3-way tie).
//  6. MEM_ARB_WR_FIRST_EN: c0 read + c2 write, ptr=0 -> c2 granted first, then c0.
//     Without the macro: c0 first, then c2.

Source files
------------

// File: rtl/mem_3_to_1_arbiter.sv
// mem_3_to_1_arbiter: round-robin sharing of one single-port memory by three clients; `define MEM_ARB_WR_FIRST_EN to favour writes over reads
module mem_3_to_1_arbiter #(
    parameter int WIDTH                = 32,
    parameter int SINGLE_MEM_DEPTH     = 14,
    parameter int FULL_MEM_DEPTH       = 42,
    parameter int SINGLE_MEM_DEPTH_LOG = $clog2(SINGLE_MEM_DEPTH),
    parameter int FULL_MEM_DEPTH_LOG   = $clog2(FULL_MEM_DEPTH),
    parameter int MEM_0_START_ADDR     = 0,
    parameter int MEM_1_START_ADDR     = 14,
    parameter int MEM_2_START_ADDR     = 28,
    parameter int RD_LATENCY           = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            c0_req,
    input  logic                            c0_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] c0_addr,
    input  logic [WIDTH-1:0]                c0_din,
    output logic                            c0_gnt,
    input  logic                            c1_req,
    input  logic                            c1_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] c1_addr,
    input  logic [WIDTH-1:0]                c1_din,
    output logic                            c1_gnt,
    input  logic                            c2_req,
    input  logic                            c2_we,
    input  logic [SINGLE_MEM_DEPTH_LOG-1:0] c2_addr,
    input  logic [WIDTH-1:0]                c2_din,
    output logic                            c2_gnt,
    output logic                            rd_valid,
    output logic [1:0]                      rd_id,
    output logic [WIDTH-1:0]                rd_data,
    output logic                            addr_err,
    output logic                            mem_wr_en,
    output logic [FULL_MEM_DEPTH_LOG-1:0]   mem_addr,
    output logic [WIDTH-1:0]                mem_din,
    input  logic [WIDTH-1:0]                mem_q
);
    localparam logic [SINGLE_MEM_DEPTH_LOG:0] SD = (SINGLE_MEM_DEPTH_LOG+1)'(SINGLE_MEM_DEPTH);
    logic [1:0] ptr, p1, p2, sel;
    logic [2:0] req_v, we_v, elig;
    logic gnt_any, oor, xfer_ok, sel_we;
    logic [SINGLE_MEM_DEPTH_LOG-1:0] sel_addr;
    logic [WIDTH-1:0] sel_din;
    logic [FULL_MEM_DEPTH_LOG-1:0] sel_base;
    logic [RD_LATENCY-1:0] pv, perr;
    logic [RD_LATENCY-1:0][1:0] pid;
    assign req_v = {c2_req, c1_req, c0_req};
    assign we_v  = {c2_we, c1_we, c0_we};
`ifdef MEM_ARB_WR_FIRST_EN
    assign elig = |(req_v & we_v) ? (req_v & we_v) : req_v;
`else
    assign elig = req_v;
`endif
    always_comb begin
        p1       = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
        p2       = (ptr == 2'd0) ? 2'd2 : ptr - 2'd1;
        gnt_any  = !rst && |elig;
        sel      = elig[ptr] ? ptr : elig[p1] ? p1 : p2;
        sel_addr = (sel == 2'd0) ? c0_addr : (sel == 2'd1) ? c1_addr : c2_addr;
        sel_din  = (sel == 2'd0) ? c0_din : (sel == 2'd1) ? c1_din : c2_din;
        sel_we   = we_v[sel];
        sel_base = (sel == 2'd0) ? FULL_MEM_DEPTH_LOG'(MEM_0_START_ADDR) :
                   (sel == 2'd1) ? FULL_MEM_DEPTH_LOG'(MEM_1_START_ADDR) :
                                   FULL_MEM_DEPTH_LOG'(MEM_2_START_ADDR);
        oor      = {1'b0, sel_addr} >= SD;
        xfer_ok  = gnt_any && !oor;
        c0_gnt   = gnt_any && sel == 2'd0;
        c1_gnt   = gnt_any && sel == 2'd1;
        c2_gnt   = gnt_any && sel == 2'd2;
        mem_wr_en = xfer_ok && sel_we;
        mem_addr  = xfer_ok ? sel_base + FULL_MEM_DEPTH_LOG'(sel_addr) : '0;
        mem_din   = xfer_ok ? sel_din : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= 2'd0;
            addr_err <= 1'b0;
            pv       <= '0;
            perr     <= '0;
            pid      <= '0;
        end else begin
            if (gnt_any)
                ptr <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
            if (gnt_any && oor)
                addr_err <= 1'b1;
            pv[0]   <= gnt_any && !sel_we;
            pid[0]  <= sel;
            perr[0] <= oor;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pv[i]   <= pv[i-1];
                pid[i]  <= pid[i-1];
                perr[i] <= perr[i-1];
            end
        end
    end
    // Out-of-range reads never touched memory, so their return word is forced to zero.
    assign rd_valid = pv[RD_LATENCY-1] && !rst;
    assign rd_id    = pid[RD_LATENCY-1];
    assign rd_data  = perr[RD_LATENCY-1] ? '0 : mem_q;
endmodule

// File: tb/tb_mem_3_to_1_arbiter.sv
// tb_mem_3_to_1_arbiter: scoreboard bench with a behavioural single-port memory behind the arbiter
module tb_mem_3_to_1_arbiter;
    typedef struct {
        logic [1:0]  id;
        logic [31:0] data;
        int          due;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0] req = '0, we = '0;
    logic [3:0] addr [3];
    logic [31:0] din [3];
    logic c0_gnt, c1_gnt, c2_gnt, rd_valid, addr_err, mem_wr_en;
    logic [1:0] rd_id;
    logic [31:0] rd_data, mem_din, mem_q;
    logic [5:0] mem_addr;
    logic [2:0] gnt;
    logic [31:0] mem [42];
    logic [31:0] ref_mem [42];
    exp_t q[$];
    int checks = 0, passed = 0, cyc_n = 0;
    assign gnt = {c2_gnt, c1_gnt, c0_gnt};
    always #5 clk = ~clk;
    mem_3_to_1_arbiter dut (
        .clk(clk), .rst(rst),
        .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_din(din[0]), .c0_gnt(c0_gnt),
        .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_din(din[1]), .c1_gnt(c1_gnt),
        .c2_req(req[2]), .c2_we(we[2]), .c2_addr(addr[2]), .c2_din(din[2]), .c2_gnt(c2_gnt),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .addr_err(addr_err),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q)
    );
    // Behavioural memory with one cycle of read latency; reloaded with a known pattern on rst.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 42; i++) mem[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_wr_en && mem_addr < 6'd42) begin
            mem[mem_addr] <= mem_din;
        end
        mem_q <= (mem_addr < 6'd42) ? mem[mem_addr] : 32'h0;
    end
    task automatic ref_init();
        for (int i = 0; i < 42; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
        q.delete();
    endtask
    task automatic adv();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask
    task automatic drv(input int n, input logic r, input logic w, input logic [3:0] a, input logic [31:0] d);
        req[n] = r; we[n] = w; addr[n] = a; din[n] = d;
    endtask
    task automatic sample(input logic [2:0] eg, input string tag);
        int k;
        exp_t e;
        @(negedge clk);
        checks++;
        if (gnt !== eg) $display("FAIL %s gnt got %b want %b", tag, gnt, eg);
        else passed++;
        if (eg != 3'b000) begin
            k = eg[0] ? 0 : eg[1] ? 1 : 2;
            if (we[k]) begin
                if (addr[k] < 4'd14) ref_mem[k*14 + int'(addr[k])] = din[k];
            end else begin
                e.id   = 2'(k);
                e.data = (addr[k] < 4'd14) ? ref_mem[k*14 + int'(addr[k])] : 32'h0;
                e.due  = cyc_n + 1;
                q.push_back(e);
            end
        end
        if (rd_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                $display("FAIL %s unexpected rd_valid id=%0d data=%h", tag, rd_id, rd_data);
            end else begin
                e = q.pop_front();
                if (rd_id !== e.id || rd_data !== e.data || e.due != cyc_n)
                    $display("FAIL %s rd got id=%0d data=%h cyc=%0d want id=%0d data=%h cyc=%0d",
                             tag, rd_id, rd_data, cyc_n, e.id, e.data, e.due);
                else passed++;
            end
        end else if (q.size() > 0 && q[0].due <= cyc_n) begin
            checks++;
            $display("FAIL %s missing rd_valid got 0 want id=%0d data=%h", tag, q[0].id, q[0].data);
            void'(q.pop_front());
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ref_init();
        adv();
        adv();
        rst = 1'b0;
    endtask
    task automatic test_reset();
        rst = 1'b1;
        ref_init();
        drv(0, 1, 0, 4'd1, 0);
        sample(3'b000, "reset_gnt_during_rst");
        adv();
        adv();
        req = '0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(3'b000, "reset_idle_gnt");
            checks++;
            if (mem_wr_en !== 1'b0 || rd_valid !== 1'b0 || addr_err !== 1'b0 || mem_addr !== 6'd0)
                $display("FAIL reset_idle got wr=%b rv=%b err=%b addr=%0d want 0 0 0 0",
                         mem_wr_en, rd_valid, addr_err, mem_addr);
            else passed++;
            adv();
        end
    endtask
    task automatic test_wr_rd();
        drv(1, 1, 1, 4'd3, 32'hA5A5_A5A5);
        sample(3'b010, "wr_gnt");
        checks++;
        if (mem_addr !== 6'd17 || mem_wr_en !== 1'b1 || mem_din !== 32'hA5A5_A5A5)
            $display("FAIL wr_port got addr=%0d wr=%b din=%h want 17 1 a5a5a5a5", mem_addr, mem_wr_en, mem_din);
        else passed++;
        adv();
        drv(1, 1, 0, 4'd3, 0);
        sample(3'b010, "rd_gnt");
        checks++;
        if (mem_addr !== 6'd17 || mem_wr_en !== 1'b0)
            $display("FAIL rd_port got addr=%0d wr=%b want 17 0", mem_addr, mem_wr_en);
        else passed++;
        adv();
        req = '0;
        sample(3'b000, "rd_return");
        checks++;
        if (mem_addr !== 6'd0 || mem_din !== 32'h0)
            $display("FAIL idle_port got addr=%0d din=%h want 0 0", mem_addr, mem_din);
        else passed++;
        adv();
    endtask
    task automatic test_round_robin();
        logic [2:0] order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        do_reset();
        drv(0, 1, 0, 4'd5, 0);
        drv(1, 1, 0, 4'd3, 0);
        drv(2, 1, 0, 4'd7, 0);
        for (int i = 0; i < 6; i++) begin
            sample(order[i], "rr_order");
            adv();
        end
        req = '0;
        sample(3'b000, "rr_drain");
        adv();
    endtask
    task automatic test_addr_err();
        do_reset();
        drv(2, 1, 1, 4'd14, 32'hDEAD_BEEF);
        sample(3'b100, "oor_wr_gnt");
        checks++;
        if (mem_wr_en !== 1'b0 || addr_err !== 1'b0)
            $display("FAIL oor_wr got wr=%b err=%b want 0 0", mem_wr_en, addr_err);
        else passed++;
        adv();
        drv(2, 1, 0, 4'd15, 0);
        sample(3'b100, "oor_rd_gnt");
        checks++;
        if (addr_err !== 1'b1) $display("FAIL oor_err_set got %b want 1", addr_err);
        else passed++;
        adv();
        drv(2, 1, 0, 4'd0, 0);
        sample(3'b100, "oor_inrange_rd");
        adv();
        req = '0;
        for (int i = 0; i < 3; i++) begin
            sample(3'b000, "oor_idle");
            checks++;
            if (addr_err !== 1'b1) $display("FAIL oor_err_sticky got %b want 1", addr_err);
            else passed++;
            adv();
        end
    endtask
    task automatic test_reset_inflight();
        do_reset();
        drv(0, 1, 0, 4'd4, 0);
        sample(3'b001, "inflight_gnt");
        adv();
        rst = 1'b1;
        req = '0;
        ref_init();
        sample(3'b000, "inflight_rst");
        checks++;
        if (rd_valid !== 1'b0) $display("FAIL inflight_rv_in_rst got %b want 0", rd_valid);
        else passed++;
        adv();
        rst = 1'b0;
        sample(3'b000, "inflight_after");
        checks++;
        if (rd_valid !== 1'b0 || addr_err !== 1'b0)
            $display("FAIL inflight_after got rv=%b err=%b want 0 0", rd_valid, addr_err);
        else passed++;
        adv();
        drv(0, 1, 0, 4'd1, 0);
        drv(1, 1, 0, 4'd1, 0);
        drv(2, 1, 0, 4'd1, 0);
        sample(3'b001, "inflight_ptr0");
        adv();
        req = '0;
        sample(3'b000, "inflight_drain");
        adv();
    endtask
    task automatic test_wr_first();
        do_reset();
        drv(0, 1, 0, 4'd2, 0);
        drv(2, 1, 1, 4'd2, 32'h1234_5678);
`ifdef MEM_ARB_WR_FIRST_EN
        sample(3'b100, "wrfirst_1");
        adv();
        req[2] = 1'b0;
        sample(3'b001, "wrfirst_2");
`else
        sample(3'b001, "rr_mix_1");
        adv();
        req[0] = 1'b0;
        sample(3'b100, "rr_mix_2");
`endif
        adv();
        req = '0;
        drv(2, 1, 0, 4'd2, 0);
        sample(3'b100, "mix_readback");
        adv();
        req = '0;
        sample(3'b000, "mix_drain");
        adv();
    endtask
    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0;
            din[i] = '0;
        end
        test_reset();
        test_wr_rd();
        test_round_robin();
        test_addr_err();
        test_reset_inflight();
        test_wr_first();
        sample(3'b000, "final_idle");
        adv();
        checks++;
        if (q.size() != 0) $display("FAIL scoreboard_empty got %0d pending want 0", q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
